// File: rtl/kcp53k_bus_arbiter.sv
// kcp53k_bus_arbiter: fair I/D arbiter onto one 64-bit bus with D-side locking and a hung-cycle watchdog.
module kcp53k_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        istb_i,
    input  logic [63:0] iadr_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic        f_cyc_o,
    output logic        f_stb_o,
    output logic        f_we_o,
    output logic [63:0] f_adr_o,
    output logic [63:0] f_dat_o,
    output logic [1:0]  f_siz_o,
    output logic        f_signed_o,
    input  logic        f_ack_i,
    input  logic [63:0] f_dat_i,
    output logic [1:0]  gnt_o,
    output logic        err_o
);
    // encoding doubles as the one-hot {D,I} grant vector
    typedef enum logic [1:0] {IDLE = 2'b00, IGNT = 2'b01, DGNT = 2'b10} state_t;
    state_t state_q, state_d, arb;
    logic last_d_q, last_d_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic igrant, dgrant, stb_raw, expire, done, pick_d;
    always_comb begin
        igrant  = state_q == IGNT;
        dgrant  = state_q == DGNT;
        stb_raw = igrant | (dgrant & dstb_i);
        expire  = (TIMEOUT != 0) && stb_raw && !f_ack_i && wd_q == CNT_W'(TIMEOUT);
        done    = (igrant | dgrant) & (f_ack_i | expire);
        pick_d  = dcyc_i & dstb_i & (~istb_i | ~last_d_q);
        arb     = pick_d ? DGNT : istb_i ? IGNT : IDLE;
        state_d = igrant ? (done ? IDLE : IGNT) : dgrant ? (dcyc_i ? DGNT : IDLE) : arb;
        last_d_d = (!igrant && !dgrant && arb != IDLE) ? pick_d : last_d_q;
        wd_d    = (!igrant && !dgrant) || state_d == IDLE || f_ack_i || expire ? '0 :
                  stb_raw ? wd_q + 1'b1 : wd_q;
    end
    always_comb begin
        gnt_o      = state_q;
        f_cyc_o    = igrant | dgrant;
        f_stb_o    = stb_raw & ~expire;
        f_we_o     = dgrant & dwe_i;
        f_adr_o    = igrant ? iadr_i : dgrant ? dadr_i : '0;
        f_dat_o    = dgrant ? ddat_i : '0;
        f_siz_o    = igrant ? 2'd2 : dgrant ? dsiz_i : 2'd0;
        f_signed_o = dgrant & dsigned_i;
        iack_o     = igrant & done;
        dack_o     = dgrant & done;
        err_o      = expire;
        idat_o     = !igrant ? '0 : expire ? '1 : f_dat_i[31:0];
        ddat_o     = !dgrant ? '0 : expire ? '1 : f_dat_i;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wd_q     <= wd_d;
        end
    end
endmodule

// File: tb/tb_kcp53k_bus_arbiter.sv
// tb_kcp53k_bus_arbiter: randomized masters and slave, transaction-level reference model, queue scoreboard.
module tb_kcp53k_bus_arbiter;
    localparam int T = 4;
    logic clk_i = 0, reset_i = 0;
    logic istb_i = 0, dcyc_i = 0, dstb_i = 0, dwe_i = 0, dsigned_i = 0, f_ack_i = 0;
    logic [63:0] iadr_i = 0, dadr_i = 0, ddat_i = 0, f_dat_i = 0;
    logic [1:0] dsiz_i = 0;
    logic iack_o, dack_o, f_cyc_o, f_stb_o, f_we_o, f_signed_o, err_o;
    logic [31:0] idat_o;
    logic [63:0] ddat_o, f_adr_o, f_dat_o;
    logic [1:0] f_siz_o, gnt_o;
    logic [239:0] act;
    always #5 clk_i = ~clk_i;
    kcp53k_bus_arbiter #(.TIMEOUT(T), .CNT_W(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .istb_i(istb_i), .iadr_i(iadr_i), .iack_o(iack_o),
        .idat_o(idat_o), .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i), .dadr_i(dadr_i),
        .ddat_i(ddat_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i), .dack_o(dack_o), .ddat_o(ddat_o),
        .f_cyc_o(f_cyc_o), .f_stb_o(f_stb_o), .f_we_o(f_we_o), .f_adr_o(f_adr_o), .f_dat_o(f_dat_o),
        .f_siz_o(f_siz_o), .f_signed_o(f_signed_o), .f_ack_i(f_ack_i), .f_dat_i(f_dat_i),
        .gnt_o(gnt_o), .err_o(err_o)
    );
    assign act = {gnt_o, f_cyc_o, f_stb_o, f_we_o, f_siz_o, f_signed_o, f_adr_o, f_dat_o,
                  iack_o, dack_o, err_o, idat_o, ddat_o};
    int checks = 0, errors = 0;
    logic [239:0] rq[$];
    logic [31:0] iq[$];
    logic [63:0] dq[$];
    int owner, wd, d_beats;
    bit last_was_d, i_busy, d_busy, d_pend;
    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction
    task automatic chk(input string nm, input logic [239:0] a, input logic [239:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
        end
    endtask
    task automatic reset_model();
        owner = 0; wd = 0; last_was_d = 1;
        i_busy = 0; d_busy = 0; d_pend = 0; d_beats = 0;
    endtask
    task automatic drive(input bit hold);
        if (!hold) begin
            if (!i_busy && $urandom_range(0, 2) == 0) begin
                i_busy = 1;
                iadr_i = r64();
            end
            if (d_busy && $urandom_range(0, 29) == 0) begin
                d_busy = 0;
                d_pend = 0;
            end else if (!d_busy && $urandom_range(0, 3) == 0) begin
                d_busy = 1;
                d_beats = $urandom_range(1, 3);
            end
            if (d_busy && !d_pend && $urandom_range(0, 1) == 0) begin
                d_pend = 1;
                dwe_i = 1'($urandom_range(0, 1));
                dadr_i = r64();
                ddat_i = r64();
                dsiz_i = 2'($urandom_range(0, 3));
                dsigned_i = 1'($urandom_range(0, 1));
            end
        end
        istb_i = i_busy;
        dcyc_i = d_busy;
        dstb_i = d_pend;
        f_ack_i = $urandom_range(0, 2) == 0;
        f_dat_i = r64();
    endtask
    task automatic model_step();
        logic [63:0] adr, dat, ddat;
        logic [31:0] idat;
        logic [1:0] siz, gnt;
        logic we, sg, raw, ex, done, ia, da;
        int nxt;
        adr = 0; dat = 0; siz = 0; we = 0; sg = 0; raw = 0;
        if (owner == 1) begin
            raw = 1; adr = iadr_i; siz = 2;
        end else if (owner == 2) begin
            raw = dstb_i; adr = dadr_i; dat = ddat_i; siz = dsiz_i; we = dwe_i; sg = dsigned_i;
        end
        ex = (T != 0) && raw && wd == T && !f_ack_i;
        done = owner != 0 && (f_ack_i || ex);
        ia = owner == 1 && done;
        da = owner == 2 && done;
        idat = owner == 1 ? (ex ? 32'hFFFF_FFFF : f_dat_i[31:0]) : 32'h0;
        ddat = owner == 2 ? (ex ? 64'hFFFF_FFFF_FFFF_FFFF : f_dat_i) : 64'h0;
        gnt = owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00;
        rq.push_back({gnt, owner != 0, raw && !ex, we, siz, sg, adr, dat, ia, da, ex, idat, ddat});
        if (ia) iq.push_back(idat);
        if (da) dq.push_back(ddat);
        if (owner == 0) begin
            if (istb_i && dcyc_i && dstb_i) nxt = last_was_d ? 1 : 2;
            else nxt = istb_i ? 1 : (dcyc_i && dstb_i) ? 2 : 0;
            if (nxt != 0) last_was_d = nxt == 2;
        end else nxt = owner == 1 ? (done ? 0 : 1) : (dcyc_i ? 2 : 0);
        wd = (owner == 0 || nxt == 0 || f_ack_i || ex) ? 0 : raw ? wd + 1 : wd;
        owner = nxt;
        if (ia) i_busy = 0;
        if (da && d_pend) begin
            d_pend = 0;
            d_beats--;
            if (d_beats == 0) d_busy = 0;
        end
    endtask
    task automatic body(input bit hold);
        drive(hold);
        model_step();
    endtask
    always @(negedge clk_i) begin
        if (reset_i) chk("reset_outputs_zero", act, '0);
        else begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL cycle_record: DUT active with no expected record at %0t", $time);
            end else chk("cycle_outputs", act, rq.pop_front());
            if (iack_o) begin
                if (iq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL iack_unexpected: got iack_o=1 expected none at %0t", $time);
                end else chk("iack_data", 240'(idat_o), 240'(iq.pop_front()));
            end
            if (dack_o) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dack_unexpected: got dack_o=1 expected none at %0t", $time);
                end else chk("dack_data", 240'(ddat_o), 240'(dq.pop_front()));
            end
        end
    end
    initial begin
        int n;
        reset_model();
        #1 reset_i = 1;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 0;
        i_busy = 1;
        iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
        body(1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #1;
            body(0);
        end
        n = 0;
        while (!(owner == 2 && d_pend) && n < 500) begin
            @(posedge clk_i); #1;
            body(0);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL locked_write_setup: got no D grant within 500 cycles expected one");
        end
        @(posedge clk_i); #1;
        dwe_i = 1;
        f_ack_i = 1;
        reset_i = 1;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 0;
        reset_model();
        i_busy = 1; d_busy = 1; d_pend = 1; d_beats = 1;
        iadr_i = r64(); dadr_i = r64(); ddat_i = r64();
        body(1);
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_i); #1;
            body(0);
        end
        @(negedge clk_i); #1;
        chk("record_queue_drained", 240'(rq.size()), '0);
        chk("iack_queue_drained", 240'(iq.size()), '0);
        chk("dack_queue_drained", 240'(dq.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
